phase_ctrl: RTL and testbench
=============================

Name: phase_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit SIMPLE-style core.
- Steps each instruction through five one-hot phases P1–P5 and decodes the IR into datapath strobes.
- Generates ld_szcv for the 4-bit flag register and evaluates conditional branches against the held flags.
- Handles the run/halt lifecycle and keeps a retired-instruction counter.

Parameters:
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  start/resume request; level sampled each clk.
- ir  in  16  instruction register contents; stable P2..P5.
- szcv  in  4  held flags: [3]=S, [2]=Z, [1]=C, [0]=V.
- phase  out  5  one-hot phase, bit0=P1 .. bit4=P5; 0 when idle or halted.
- ld_ir  out  1  load IR from memory data.
- pc_inc  out  1  PC <= PC+1.
- ld_pc_br  out  1  PC <= branch target.
- ld_szcv  out  1  flag register takes the ALU flags.
- mem_re  out  1  data-memory read.
- mem_we  out  1  data-memory write.
- out_en  out  1  output-port strobe.
- reg_we  out  1  register-file write.
- halted  out  1  core stopped by HLT.
- icount  out  ICNT_W  retired-instruction count.

Behaviour:
- States: IDLE, RUN (phase P1..P5), HALT. Register phase and state; decode strobes combinationally from phase and ir.
- Reset (async): state=IDLE, phase=0, halted=0, icount=0. All strobes are 0 during and after reset until RUN.
- IDLE: run=1 -> P1 on the next edge.
- HALT: halted=1 and phase=0. run=1 -> P1 and halted cleared on the same edge.
- RUN: phases advance P1->P2->P3->P4->P5->P1, one clk each, regardless of run. Latency is 5 clk per instruction.
- Decode fields:
  - op1 = ir[15:14]; op3 = ir[7:4] for op1=11; op2 = ir[13:11] for op1=10; cond = ir[10:8].
  - ALU ops: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, CMP=0101, MOV=0110, SLL=1000, SLR=1001, SRL=1010, SRA=1011.
  - I/O and control: IN=1100, OUT=1101, HLT=1111.
  - op1=00 is LD; op1=01 is ST.
  - op1=10: op2=000 is LI, 100 is B, 111 is Bcc.
- P1: ld_ir=1 and pc_inc=1.
- P2: no strobes (register read).
- P3:
  - ld_szcv=1 for ADD, SUB, AND, OR, XOR, CMP, SLL, SLR, SRL, SRA.
  - ld_szcv=0 for MOV, IN, OUT, LD, ST, LI, branches, HLT and undefined op3.
  - ld_pc_br=1 for B, or for Bcc with a true condition.
  - Conditions: cond=000 BE: Z. 001 BLT: S^V. 010 BLE: Z|(S^V). 011 BNE: !Z. Other cond values are never taken.
  - Flags are those held before this instruction's P3; the flag register updates at the P3 edge, so a branch never sees its own instruction's flags.
- P4: mem_re=1 for LD; mem_we=1 for ST; out_en=1 for OUT.
- P5:
  - reg_we=1 for ALU ops except CMP, and for IN, LD, LI.
  - icount increments and wraps from all-ones to 0.
  - If the op is HLT: next state is HALT instead of P1.
- Undefined opcodes behave as NOP: five phases, no strobes, still counted.
- Strobes are mutually exclusive per phase; at most one PC-load strobe is active in any cycle.
- Reset asserted mid-instruction aborts immediately to IDLE with all strobes 0; icount clears.
- run held high continuously does not re-trigger or skip phases.

Decomposition:
- Shared package: op1/op2/op3/cond encodings, phase one-hot constants, flag bit indices.
- One natural sub-module: branch_eval (combinational; inputs cond and szcv; output taken).

Test Plan:
- Reset then run=1 with ir=ADD (0xC000) -> phase 1,2,4,8,16 on successive clks; ld_szcv=1 only at P3; reg_we=1 only at P5; icount=1.
- CMP (0xC050) -> ld_szcv=1 at P3, reg_we=0 at P5; MOV (0xC060) -> ld_szcv=0, reg_we=1.
- Bcc BLT (ir[15:11]=10111, cond=001):
  - szcv=4'b1000 -> ld_pc_br=1 at P3.
  - szcv=4'b1001 -> ld_pc_br=0.
- BE with szcv=4'b0100 -> ld_pc_br=1; BNE with the same flags -> ld_pc_br=0; B (op2=100) -> always taken.
- HLT (0xC0F0) -> after P5, halted=1 and phase=0 for 10 clk while run=0; run pulse -> next clk P1 and halted=0.
- Assert rst during P3 of LD -> phase=0 and all strobes 0 immediately; after release, IDLE until run=1; icount=0.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
// rtl/phase_ctrl_pkg.sv - encodings, phase constants and flag indices for phase_ctrl
package phase_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // op1 = ir[15:14]
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 = ir[13:11] when op1 = 10
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // op3 = ir[7:4] when op1 = 11
    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_SUB = 4'b0001;
    localparam logic [3:0] OP3_AND = 4'b0010;
    localparam logic [3:0] OP3_OR  = 4'b0011;
    localparam logic [3:0] OP3_XOR = 4'b0100;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_MOV = 4'b0110;
    localparam logic [3:0] OP3_SLL = 4'b1000;
    localparam logic [3:0] OP3_SLR = 4'b1001;
    localparam logic [3:0] OP3_SRL = 4'b1010;
    localparam logic [3:0] OP3_SRA = 4'b1011;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // cond = ir[10:8]
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam logic [4:0] PH_P1 = 5'b00001;
    localparam logic [4:0] PH_P2 = 5'b00010;
    localparam logic [4:0] PH_P3 = 5'b00100;
    localparam logic [4:0] PH_P4 = 5'b01000;
    localparam logic [4:0] PH_P5 = 5'b10000;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ALU ops that update the flag register (MOV and I/O do not)
    function automatic logic op3_sets_flags(input logic [3:0] op3);
        case (op3)
            OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_CMP,
            OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA: op3_sets_flags = 1'b1;
            default:                            op3_sets_flags = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/phase_ctrl_if.sv
// rtl/phase_ctrl_if.sv - core-side bundle of phase_ctrl inputs, phase and strobes
interface phase_ctrl_if #(
    parameter int ICNT_W = 16
);
    logic              run;
    logic [15:0]       ir;
    logic [3:0]        szcv;
    logic [4:0]        phase;
    logic              ld_ir;
    logic              pc_inc;
    logic              ld_pc_br;
    logic              ld_szcv;
    logic              mem_re;
    logic              mem_we;
    logic              out_en;
    logic              reg_we;
    logic              halted;
    logic [ICNT_W-1:0] icount;

    modport master (
        output run, ir, szcv,
        input  phase, ld_ir, pc_inc, ld_pc_br, ld_szcv, mem_re, mem_we,
               out_en, reg_we, halted, icount
    );

    modport slave (
        input  run, ir, szcv,
        output phase, ld_ir, pc_inc, ld_pc_br, ld_szcv, mem_re, mem_we,
               out_en, reg_we, halted, icount
    );
endinterface

// File: rtl/phase_ctrl_branch_eval.sv
// rtl/phase_ctrl_branch_eval.sv - conditional-branch test against held flags
module phase_ctrl_branch_eval
    import phase_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] szcv,
    output logic       taken
);
    logic s_xor_v;
    logic unused_carry;

    assign s_xor_v      = szcv[FLAG_S] ^ szcv[FLAG_V];
    assign unused_carry = szcv[FLAG_C];

    // evaluate the branch condition; reserved conditions are never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = szcv[FLAG_Z];
            COND_BLT: taken = s_xor_v;
            COND_BLE: taken = szcv[FLAG_Z] | s_xor_v;
            COND_BNE: taken = ~szcv[FLAG_Z];
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/phase_ctrl.sv
// rtl/phase_ctrl.sv - five-phase instruction sequencer and strobe decoder
module phase_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int ICNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    phase_ctrl_if.slave bus
);
    state_t            state_q, state_d;
    logic [4:0]        phase_q, phase_d;
    logic [ICNT_W-1:0] icount_q;

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    logic       is_alu, is_hlt, br_taken;
    logic       unused_ir;

    assign op1       = bus.ir[15:14];
    assign op2       = bus.ir[13:11];
    assign op3       = bus.ir[7:4];
    assign is_alu    = (op1 == OP1_ALU);
    assign is_hlt    = is_alu && (op3 == OP3_HLT);
    assign unused_ir = ^bus.ir[3:0];

    phase_ctrl_branch_eval u_branch_eval (
        .cond  (bus.ir[10:8]),
        .szcv  (bus.szcv),
        .taken (br_taken)
    );

    // state, phase and retired count; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            icount_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (state_q == ST_RUN && phase_q == PH_P5)
                icount_q <= icount_q + 1'b1;
        end
    end

    // next state: run only starts an instruction from IDLE/HALT; RUN ignores it
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                    phase_d = PH_P1;
                end
            end
            ST_RUN: begin
                if (phase_q == PH_P5) begin
                    if (is_hlt) begin
                        state_d = ST_HALT;
                        phase_d = '0;
                    end else begin
                        phase_d = PH_P1;
                    end
                end else if (phase_q == '0) begin
                    phase_d = PH_P1;
                end else begin
                    phase_d = {phase_q[3:0], 1'b0};
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // strobes decode from the registered phase, so they drop with reset at once
    always_comb begin
        bus.ld_ir    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.ld_pc_br = 1'b0;
        bus.ld_szcv  = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.out_en   = 1'b0;
        bus.reg_we   = 1'b0;
        case (phase_q)
            PH_P1: begin
                bus.ld_ir  = 1'b1;
                bus.pc_inc = 1'b1;
            end
            PH_P3: begin
                bus.ld_szcv  = is_alu && op3_sets_flags(op3);
                bus.ld_pc_br = (op1 == OP1_IMM) &&
                               ((op2 == OP2_B) || (op2 == OP2_BCC && br_taken));
            end
            PH_P4: begin
                bus.mem_re = (op1 == OP1_LD);
                bus.mem_we = (op1 == OP1_ST);
                bus.out_en = is_alu && (op3 == OP3_OUT);
            end
            PH_P5: begin
                bus.reg_we = (op1 == OP1_LD) ||
                             (op1 == OP1_IMM && op2 == OP2_LI) ||
                             (is_alu && ((op3_sets_flags(op3) && op3 != OP3_CMP) ||
                                         op3 == OP3_MOV || op3 == OP3_IN));
            end
            default: ;
        endcase
    end

    assign bus.phase  = phase_q;
    assign bus.halted = (state_q == ST_HALT);
    assign bus.icount = icount_q;
endmodule

// File: tb/tb_phase_ctrl.sv
// tb/tb_phase_ctrl.sv - directed self-checking bench for phase_ctrl
module tb_phase_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_retired = 0;

    phase_ctrl_if #(.ICNT_W(16)) bus ();

    phase_ctrl #(.ICNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] strobes;
    assign strobes = {bus.ld_ir, bus.pc_inc, bus.ld_pc_br, bus.ld_szcv,
                      bus.mem_re, bus.mem_we, bus.out_en, bus.reg_we};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full instruction; expected strobes given per phase by the caller
    task automatic exec(input string name, input logic [15:0] ir_v, input logic [3:0] flags,
                        input logic sz, input logic br, input logic re, input logic we,
                        input logic oe, input logic rwe);
        tick();
        chk({name, ".p1.phase"}, {27'd0, bus.phase}, 32'h01);
        chk({name, ".p1.strobes"}, {24'd0, strobes}, 32'hC0);
        chk({name, ".p1.halted"}, {31'd0, bus.halted}, 32'd0);
        chk({name, ".p1.icount"}, {16'd0, bus.icount}, n_retired);
        bus.ir   = ir_v;
        bus.szcv = flags;
        tick();
        chk({name, ".p2.phase"}, {27'd0, bus.phase}, 32'h02);
        chk({name, ".p2.strobes"}, {24'd0, strobes}, 32'h00);
        tick();
        chk({name, ".p3.phase"}, {27'd0, bus.phase}, 32'h04);
        chk({name, ".p3.strobes"}, {24'd0, strobes}, {24'd0, 2'b00, br, sz, 4'b0000});
        tick();
        chk({name, ".p4.phase"}, {27'd0, bus.phase}, 32'h08);
        chk({name, ".p4.strobes"}, {24'd0, strobes}, {24'd0, 4'b0000, re, we, oe, 1'b0});
        tick();
        chk({name, ".p5.phase"}, {27'd0, bus.phase}, 32'h10);
        chk({name, ".p5.strobes"}, {24'd0, strobes}, {24'd0, 7'd0, rwe});
        n_retired++;
    endtask

    initial begin
        bus.run  = 1'b0;
        bus.ir   = 16'h0000;
        bus.szcv = 4'b0000;
        #12;
        chk("reset.phase", {27'd0, bus.phase}, 32'd0);
        chk("reset.strobes", {24'd0, strobes}, 32'd0);
        chk("reset.halted", {31'd0, bus.halted}, 32'd0);
        chk("reset.icount", {16'd0, bus.icount}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle.phase", {27'd0, bus.phase}, 32'd0);
        chk("idle.strobes", {24'd0, strobes}, 32'd0);

        // run held high across many instructions
        bus.run = 1'b1;
        //          name   ir       szcv     sz br re we oe rwe
        exec("add",  16'hC000, 4'b0000, 1, 0, 0, 0, 0, 1);
        exec("cmp",  16'hC050, 4'b0000, 1, 0, 0, 0, 0, 0);
        exec("mov",  16'hC060, 4'b0000, 0, 0, 0, 0, 0, 1);
        exec("blt_t",16'hB900, 4'b1000, 0, 1, 0, 0, 0, 0);
        exec("blt_n",16'hB900, 4'b1001, 0, 0, 0, 0, 0, 0);
        exec("be_t", 16'hB800, 4'b0100, 0, 1, 0, 0, 0, 0);
        exec("bne_n",16'hBB00, 4'b0100, 0, 0, 0, 0, 0, 0);
        exec("bne_t",16'hBB00, 4'b0000, 0, 1, 0, 0, 0, 0);
        exec("ble_t",16'hBA00, 4'b0001, 0, 1, 0, 0, 0, 0);
        exec("ble_n",16'hBA00, 4'b1001, 0, 0, 0, 0, 0, 0);
        exec("bcc_rsv",16'hBC00, 4'b1111, 0, 0, 0, 0, 0, 0);
        exec("b",    16'hA000, 4'b0000, 0, 1, 0, 0, 0, 0);
        exec("li",   16'h8000, 4'b0000, 0, 0, 0, 0, 0, 1);
        exec("ld",   16'h0000, 4'b0000, 0, 0, 1, 0, 0, 1);
        exec("st",   16'h4000, 4'b0000, 0, 0, 0, 1, 0, 0);
        exec("in",   16'hC0C0, 4'b0000, 0, 0, 0, 0, 0, 1);
        exec("out",  16'hC0D0, 4'b0000, 0, 0, 0, 0, 1, 0);
        exec("sra",  16'hC0B0, 4'b0000, 1, 0, 0, 0, 0, 1);
        exec("undef",16'hC070, 4'b0000, 0, 0, 0, 0, 0, 0);
        exec("und10",16'h8800, 4'b1111, 0, 0, 0, 0, 0, 0);

        // halt lifecycle
        bus.run = 1'b0;
        exec("hlt",  16'hC0F0, 4'b0000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt.phase", {27'd0, bus.phase}, 32'd0);
            chk("halt.halted", {31'd0, bus.halted}, 32'd1);
            chk("halt.strobes", {24'd0, strobes}, 32'd0);
        end
        chk("halt.icount", {16'd0, bus.icount}, n_retired);
        bus.run = 1'b1;
        exec("resume", 16'hC010, 4'b0000, 1, 0, 0, 0, 0, 1);
        bus.run = 1'b0;

        // reset in P3 of LD aborts at once, without a clock edge
        tick();
        chk("ld.p1.phase", {27'd0, bus.phase}, 32'h01);
        bus.ir = 16'h0000;
        tick();
        tick();
        chk("ld.p3.phase", {27'd0, bus.phase}, 32'h04);
        rst = 1'b1;
        #1;
        chk("abort.phase", {27'd0, bus.phase}, 32'd0);
        chk("abort.strobes", {24'd0, strobes}, 32'd0);
        chk("abort.icount", {16'd0, bus.icount}, 32'd0);
        chk("abort.halted", {31'd0, bus.halted}, 32'd0);
        tick();
        rst = 1'b0;
        n_retired = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post.idle.phase", {27'd0, bus.phase}, 32'd0);
            chk("post.idle.strobes", {24'd0, strobes}, 32'd0);
        end
        bus.run = 1'b1;
        exec("post.add", 16'hC000, 4'b0000, 1, 0, 0, 0, 0, 1);
        tick();
        chk("post.icount", {16'd0, bus.icount}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
